tank_ctrl: RTL and testbench

Per-player tank controller, parametrised successor to the single-tank mover. Runs once per frame on frame_clk. Decodes up to two simultaneous keys, including 8-way diagonals and a fire key. Moves the tank with wall clamping and blocks moves that would overlap the opposing tank. Adds health, hit invulnerability, death/respawn sequencing and a rate-limited fire pulse for the projectile block.

---
 rtl/tank_ctrl_if.sv | 22 ++
 rtl/tank_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_tank_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tank_ctrl_if.sv
// Per-player tank controller bus: key/hit/spawn inputs and registered tank state outputs.
interface tank_ctrl_if;
  logic [15:0] keycode;
  logic        ball_hit;
  logic [9:0]  tXcenter, tYcenter;
  logic [9:0]  otherTankX, otherTankY;
  logic [9:0]  tankX, tankY;
  logic [2:0]  facing;
  logic        fire;
  logic [1:0]  hp;
  logic        alive;
  logic        invuln;

  modport master (
    output keycode, ball_hit, tXcenter, tYcenter, otherTankX, otherTankY,
    input  tankX, tankY, facing, fire, hp, alive, invuln
  );
  modport slave (
    input  keycode, ball_hit, tXcenter, tYcenter, otherTankX, otherTankY,
    output tankX, tankY, facing, fire, hp, alive, invuln
  );
endinterface

// File: rtl/tank_ctrl.sv
// Per-frame tank controller: 8-way movement with wall clamp and tank-tank blocking,
// health / invulnerability / death-respawn FSM and rate-limited fire pulse.
module tank_ctrl #(
  parameter int X_MIN          = 1,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 1,
  parameter int Y_MAX          = 479,
  parameter int STEP           = 2,
  parameter int HALF           = 8,
  parameter int HP_INIT        = 3,
  parameter int COOLDOWN       = 15,
  parameter int INVULN_FRAMES  = 30,
  parameter int RESPAWN_FRAMES = 60,
  parameter logic [7:0] KEY_UP    = 8'h1A,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_FIRE  = 8'h2C
) (
  input logic       frame_clk,
  input logic       Reset,
  tank_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_e;

  localparam int TMAX = (INVULN_FRAMES > RESPAWN_FRAMES) ? INVULN_FRAMES : RESPAWN_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic signed [10:0] XLO    = 11'(X_MIN + HALF);
  localparam logic signed [10:0] XHI    = 11'(X_MAX - HALF);
  localparam logic signed [10:0] YLO    = 11'(Y_MIN + HALF);
  localparam logic signed [10:0] YHI    = 11'(Y_MAX - HALF);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] SPAN   = 11'(2 * HALF);

  function automatic logic pressed(input logic [15:0] kc, input logic [7:0] code);
    return (kc[15:8] == code) || (kc[7:0] == code);
  endfunction

  // dir = {dec, inc}; the clamp lands exactly on the wall rather than stopping short
  function automatic logic signed [10:0] step_clamp(input logic [9:0] pos, input logic [1:0] dir,
                                                    input logic signed [10:0] lo,
                                                    input logic signed [10:0] hi);
    logic signed [10:0] c;
    c = $signed({1'b0, pos});
    if (dir != 2'b00) begin
      c = dir[0] ? c + STEP_S : c - STEP_S;
      if (c < lo)      c = lo;
      else if (c > hi) c = hi;
    end
    return c;
  endfunction

  function automatic logic overlap(input logic signed [10:0] ax, input logic signed [10:0] ay,
                                   input logic signed [10:0] bx, input logic signed [10:0] by);
    logic signed [10:0] ddx, ddy;
    ddx = ax - bx;
    ddy = ay - by;
    if (ddx < 0) ddx = -ddx;
    if (ddy < 0) ddy = -ddy;
    return (ddx < SPAN) && (ddy < SPAN);
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cd_q, cd_d;
  logic [1:0]      hp_q, hp_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [2:0]      facing_q, facing_d;
  logic            fire_q, fire_d;

  logic            up, dn, lf, rt, fk;
  logic [1:0]      xd, yd;
  logic [2:0]      dir;
  logic            dir_vld;
  logic signed [10:0] cur_x, cur_y, oth_x, oth_y, cand_x, cand_y, new_x, new_y;

  assign up = pressed(bus.keycode, KEY_UP);
  assign dn = pressed(bus.keycode, KEY_DOWN);
  assign lf = pressed(bus.keycode, KEY_LEFT);
  assign rt = pressed(bus.keycode, KEY_RIGHT);
  assign fk = pressed(bus.keycode, KEY_FIRE);

  // opposing keys cancel on their axis
  assign xd = {lf & ~rt, rt & ~lf};
  assign yd = {up & ~dn, dn & ~up};

  assign cur_x = $signed({1'b0, x_q});
  assign cur_y = $signed({1'b0, y_q});
  assign oth_x = $signed({1'b0, bus.otherTankX});
  assign oth_y = $signed({1'b0, bus.otherTankY});

  // X is tested at the current Y; Y is tested at the already-resolved X
  assign cand_x = step_clamp(x_q, xd, XLO, XHI);
  assign new_x  = overlap(cand_x, cur_y, oth_x, oth_y) ? cur_x : cand_x;
  assign cand_y = step_clamp(y_q, yd, YLO, YHI);
  assign new_y  = overlap(new_x, cand_y, oth_x, oth_y) ? cur_y : cand_y;

  always_comb begin
    dir     = 3'd0;
    dir_vld = 1'b1;
    case ({xd, yd})  // {left, right, up, down}
      4'b00_10: dir = 3'd0;
      4'b01_10: dir = 3'd1;
      4'b01_00: dir = 3'd2;
      4'b01_01: dir = 3'd3;
      4'b00_01: dir = 3'd4;
      4'b10_01: dir = 3'd5;
      4'b10_00: dir = 3'd6;
      4'b10_10: dir = 3'd7;
      default:  dir_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hp_d     = hp_q;
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    fire_d   = 1'b0;
    cd_d     = (cd_q != '0) ? cd_q - 1'b1 : '0;
    if (fk && cd_q == '0 && state_q != DEAD) begin
      fire_d = 1'b1;
      cd_d   = CW'(COOLDOWN);
    end
    case (state_q)
      ALIVE, INVULN: begin
        x_d = 10'(new_x);
        y_d = 10'(new_y);
        if (dir_vld) facing_d = dir;
        if (state_q == ALIVE) begin
          if (bus.ball_hit) begin
            hp_d = hp_q - 2'd1;
            if (hp_q == 2'd1) begin
              state_d = DEAD;
              timer_d = TW'(RESPAWN_FRAMES);
              x_d     = x_q;
              y_d     = y_q;
            end else begin
              state_d = INVULN;
              timer_d = TW'(INVULN_FRAMES);
            end
          end
        end else begin
          timer_d = timer_q - 1'b1;
          if (timer_q <= TW'(1)) begin
            state_d = ALIVE;
            timer_d = '0;
          end
        end
      end
      default: begin
        timer_d = timer_q - 1'b1;
        if (timer_q <= TW'(1)) begin
          state_d = INVULN;
          timer_d = TW'(INVULN_FRAMES);
          hp_d    = 2'(HP_INIT);
          x_d     = bus.tXcenter;
          y_d     = bus.tYcenter;
        end
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ALIVE;
      timer_q  <= '0;
      cd_q     <= '0;
      hp_q     <= 2'(HP_INIT);
      x_q      <= bus.tXcenter;
      y_q      <= bus.tYcenter;
      facing_q <= 3'd0;
      fire_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cd_q     <= cd_d;
      hp_q     <= hp_d;
      x_q      <= x_d;
      y_q      <= y_d;
      facing_q <= facing_d;
      fire_q   <= fire_d;
    end
  end

  assign bus.tankX  = x_q;
  assign bus.tankY  = y_q;
  assign bus.facing = facing_q;
  assign bus.fire   = fire_q;
  assign bus.hp     = hp_q;
  assign bus.alive  = (state_q != DEAD);
  assign bus.invuln = (state_q == INVULN);

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl: expected outputs queued per frame, checked after each edge.
module tb_tank_ctrl;
  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  tank_ctrl_if bus();
  tank_ctrl u_dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus.slave));

  typedef struct packed {
    logic [63:0] tag;
    logic [9:0]  x, y;
    logic [2:0]  f;
    logic        fire;
    logic [1:0]  hp;
    logic        alive, inv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [63:0] t, input logic [9:0] x, input logic [9:0] y,
                              input logic [2:0] f, input logic fi, input logic [1:0] hp,
                              input logic al, input logic iv);
    exp_t e;
    e.tag = t; e.x = x; e.y = y; e.f = f; e.fire = fi; e.hp = hp; e.alive = al; e.inv = iv;
    return e;
  endfunction

  task automatic cmp(input logic [63:0] tag, input string fld, input logic [9:0] got,
                     input logic [9:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic drain();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "x",      bus.tankX,           e.x);
      cmp(e.tag, "y",      bus.tankY,           e.y);
      cmp(e.tag, "facing", 10'(bus.facing),     10'(e.f));
      cmp(e.tag, "fire",   10'(bus.fire),       10'(e.fire));
      cmp(e.tag, "hp",     10'(bus.hp),         10'(e.hp));
      cmp(e.tag, "alive",  10'(bus.alive),      10'(e.alive));
      cmp(e.tag, "invuln", 10'(bus.invuln),     10'(e.inv));
    end
  endtask

  task automatic step(input logic [15:0] kc, input logic hit, input exp_t e);
    bus.keycode  = kc;
    bus.ball_hit = hit;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    drain();
  endtask

  task automatic do_reset(input logic [9:0] sx, input logic [9:0] sy,
                          input logic [9:0] ox, input logic [9:0] oy);
    bus.keycode    = 16'h0000;
    bus.ball_hit   = 1'b0;
    bus.tXcenter   = sx;
    bus.tYcenter   = sy;
    bus.otherTankX = ox;
    bus.otherTankY = oy;
    Reset = 1'b0;
    #1;
    sb.push_back(mk("rst", sx, sy, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));
    drain();
    @(posedge frame_clk);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    logic [15:0] kc;
    logic        hit;
    logic [9:0]  ex;
    logic [1:0]  ehp;
    logic        eal, einv;
    #2;

    // straight up
    do_reset(10'd100, 10'd200, 10'd500, 10'd400);
    for (int i = 1; i <= 5; i++)
      step(16'h001A, 1'b0, mk("up", 10'd100, 10'(200 - 2 * i), 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));

    // left into the wall: lands on X_MIN+HALF = 9
    do_reset(10'd12, 10'd240, 10'd500, 10'd400);
    step(16'h0004, 1'b0, mk("left", 10'd10, 10'd240, 3'd6, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h0004, 1'b0, mk("left", 10'd9,  10'd240, 3'd6, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h0004, 1'b0, mk("left", 10'd9,  10'd240, 3'd6, 1'b0, 2'd3, 1'b1, 1'b0));

    // diagonal NE, then up+down cancels with facing held
    do_reset(10'd300, 10'd300, 10'd500, 10'd400);
    for (int i = 1; i <= 3; i++)
      step(16'h1A07, 1'b0, mk("ne", 10'(300 + 2 * i), 10'(300 - 2 * i), 3'd1, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h1A16, 1'b0, mk("cancel", 10'd306, 10'd294, 3'd1, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h1A16, 1'b0, mk("cancel", 10'd306, 10'd294, 3'd1, 1'b0, 2'd3, 1'b1, 1'b0));

    // SE into the far corner: X_MAX-HALF = 631, Y_MAX-HALF = 471
    do_reset(10'd628, 10'd468, 10'd100, 10'd100);
    step(16'h1607, 1'b0, mk("se", 10'd630, 10'd470, 3'd3, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h1607, 1'b0, mk("se", 10'd631, 10'd471, 3'd3, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h1607, 1'b0, mk("se", 10'd631, 10'd471, 3'd3, 1'b0, 2'd3, 1'b1, 1'b0));

    // blocked by the other tank on X
    do_reset(10'd100, 10'd100, 10'd120, 10'd100);
    step(16'h0007, 1'b0, mk("blkx", 10'd102, 10'd100, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h0007, 1'b0, mk("blkx", 10'd104, 10'd100, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h0007, 1'b0, mk("blkx", 10'd104, 10'd100, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h0007, 1'b0, mk("blkx", 10'd104, 10'd100, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0));

    // blocked by the other tank on Y
    do_reset(10'd100, 10'd100, 10'd100, 10'd80);
    step(16'h001A, 1'b0, mk("blky", 10'd100, 10'd98, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h001A, 1'b0, mk("blky", 10'd100, 10'd96, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));
    step(16'h001A, 1'b0, mk("blky", 10'd100, 10'd96, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));

    // held fire: pulses at frames 1 and 17; second half uses the upper key slot
    do_reset(10'd300, 10'd300, 10'd500, 10'd400);
    for (int f = 1; f <= 20; f++) begin
      kc = (f <= 10) ? 16'h002C : 16'h2C00;
      step(kc, 1'b0, mk("fire", 10'd300, 10'd300, 3'd0, (f == 1 || f == 17), 2'd3, 1'b1, 1'b0));
    end

    // hits at 1,10,41,72; moves at 1 and 5; keys and fire ignored while dead; respawn at 132
    do_reset(10'd200, 10'd200, 10'd500, 10'd400);
    for (int f = 1; f <= 135; f++) begin
      hit = (f == 1 || f == 10 || f == 41 || f == 72);
      if (f == 1 || f == 5 || (f >= 72 && f <= 80)) kc = 16'h0007;
      else if (f >= 81 && f <= 90)                 kc = 16'h002C;
      else                                         kc = 16'h0000;
      ex   = (f >= 132) ? 10'd200 : ((f >= 5) ? 10'd204 : 10'd202);
      ehp  = (f >= 132) ? 2'd3 : (f >= 72) ? 2'd0 : (f >= 41) ? 2'd1 : 2'd2;
      eal  = !(f >= 72 && f <= 131);
      einv = (f <= 30) || (f >= 41 && f <= 70) || (f >= 132);
      step(kc, hit, mk("life", ex, 10'd200, 3'd2, 1'b0, ehp, eal, einv));
    end

    // quick death, then reset while dead
    do_reset(10'd50, 10'd60, 10'd500, 10'd400);
    for (int f = 1; f <= 66; f++) begin
      hit  = (f == 1 || f == 32 || f == 63);
      ehp  = (f >= 63) ? 2'd0 : (f >= 32) ? 2'd1 : 2'd2;
      eal  = (f < 63);
      einv = (f <= 30) || (f >= 32 && f <= 61);
      step(16'h0000, hit, mk("death", 10'd50, 10'd60, 3'd0, 1'b0, ehp, eal, einv));
    end
    Reset = 1'b0;
    #1;
    sb.push_back(mk("rstdead", 10'd50, 10'd60, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0));
    drain();
    @(posedge frame_clk);
    #1;
    Reset = 1'b1;
    step(16'h0007, 1'b0, mk("postrst", 10'd52, 10'd60, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
